// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
//
// Multi-cycle MIPS control FSM. Sequences a shared ALU, a unified
// instruction/data memory and the register file over several cycles per
// instruction, and runs a ready-based wait handshake with memory.
//
// state | meaning
// ------+----------------------------------------------------------
// IF    | instruction fetch, PC+4 -> PC; waits on mem_ready
// ID    | decode, branch target -> ALUOut, dispatch on OpCode
// MA    | lw/sw effective address calculation
// MR    | lw memory read; waits on mem_ready
// MWB   | lw write-back from MDR into rt
// MW    | sw memory write; waits on mem_ready
// EXR   | R-type execute, ALU op from Funct
// RWB   | R-type write-back from ALUOut into rd
// EXI   | addi/ori execute with extended immediate
// IWB   | immediate write-back from ALUOut into rt
// BR    | beq compare, conditional PC write
// JMP   | jump, PC <- {PC[31:28], IR[25:0], 00}
//
// Ports:
//   clk, rst (sync, active high)      clock and reset
//   OpCode, Funct                     instruction fields from IR
//   mem_ready                         memory completes the access this cycle
//   Zero                              ALU zero flag (qualified in the datapath)
//   MemRd, MemWr, IorD                memory strobes and address select
//   IRWr, PCWr, PCWrCond              IR / PC write enables
//   RegDst, RegWr, Mem2Reg            register file controls
//   ALUSrcA, ALUSrcB, ExtOp, ALUCtr   ALU operand selects and operation
//   PCSrc                             PC source select
//   instr_done, illegal               one-cycle status pulses
// -----------------------------------------------------------------------------
module multi_cycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  input  logic       Zero,
  output logic       MemRd,
  output logic       MemWr,
  output logic       IorD,
  output logic       IRWr,
  output logic       PCWr,
  output logic       PCWrCond,
  output logic       RegDst,
  output logic       RegWr,
  output logic       Mem2Reg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic [1:0] PCSrc,
  output logic [3:0] ALUCtr,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_MA, S_MR, S_MWB, S_MW,
    S_EXR, S_RWB, S_EXI, S_IWB, S_BR, S_JMP
  } state_t;

  state_t state, next_state;

  // The branch decision (PCWrCond & Zero) is taken in the datapath, so the
  // flag is intentionally not consumed here.
  logic zero_unused;
  assign zero_unused = Zero;

  // R-type function decode shared by next-state and output logic
  logic       funct_ok;
  logic [3:0] funct_ctr;

  always_comb begin
    funct_ok  = 1'b1;
    funct_ctr = ALU_ADD;
    case (Funct)
      6'b100000: funct_ctr = ALU_ADD;
      6'b100010: funct_ctr = ALU_SUB;
      6'b100100: funct_ctr = ALU_AND;
      6'b100101: funct_ctr = ALU_OR;
      6'b101010: funct_ctr = ALU_SLT;
      default: begin
        funct_ok  = 1'b0;
        funct_ctr = ALU_ADD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IF;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IF:  if (mem_ready) next_state = S_ID;
      S_ID: begin
        case (OpCode)
          OP_RTYPE:       next_state = S_EXR;
          OP_LW, OP_SW:   next_state = S_MA;
          OP_ADDI, OP_ORI: next_state = S_EXI;
          OP_BEQ:         next_state = S_BR;
          OP_J:           next_state = S_JMP;
          default:        next_state = S_IF;
        endcase
      end
      S_MA:  next_state = (OpCode == OP_SW) ? S_MW : S_MR;
      S_MR:  if (mem_ready) next_state = S_MWB;
      S_MWB: next_state = S_IF;
      S_MW:  if (mem_ready) next_state = S_IF;
      S_EXR: next_state = funct_ok ? S_RWB : S_IF;
      S_RWB: next_state = S_IF;
      S_EXI: next_state = S_IWB;
      S_IWB: next_state = S_IF;
      S_BR:  next_state = S_IF;
      S_JMP: next_state = S_IF;
      default: next_state = S_IF;
    endcase
  end

  // Reset gates every output so no strobe or write enable leaks while the
  // state register is being forced back to IF.
  always_comb begin
    MemRd      = 1'b0;
    MemWr      = 1'b0;
    IorD       = 1'b0;
    IRWr       = 1'b0;
    PCWr       = 1'b0;
    PCWrCond   = 1'b0;
    RegDst     = 1'b0;
    RegWr      = 1'b0;
    Mem2Reg    = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ExtOp      = 1'b0;
    PCSrc      = 2'b00;
    ALUCtr     = 4'b0000;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (state)
        S_IF: begin
          MemRd   = 1'b1;
          ALUSrcB = 2'b01;
          ALUCtr  = ALU_ADD;
          IRWr    = mem_ready;
          PCWr    = mem_ready;
        end
        S_ID: begin
          ALUSrcB = 2'b11;
          ExtOp   = 1'b1;
          ALUCtr  = ALU_ADD;
          case (OpCode)
            OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ORI, OP_BEQ, OP_J: illegal = 1'b0;
            default: illegal = 1'b1;
          endcase
        end
        S_MA: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ExtOp   = 1'b1;
          ALUCtr  = ALU_ADD;
        end
        S_MR: begin
          MemRd = 1'b1;
          IorD  = 1'b1;
        end
        S_MWB: begin
          RegWr      = 1'b1;
          Mem2Reg    = 1'b1;
          instr_done = 1'b1;
        end
        S_MW: begin
          MemWr      = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXR: begin
          ALUSrcA = 1'b1;
          ALUCtr  = funct_ctr;
          illegal = ~funct_ok;
        end
        S_RWB: begin
          RegWr      = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_EXI: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          if (OpCode == OP_ORI) begin
            ExtOp  = 1'b0;
            ALUCtr = ALU_OR;
          end else begin
            ExtOp  = 1'b1;
            ALUCtr = ALU_ADD;
          end
        end
        S_IWB: begin
          RegWr      = 1'b1;
          instr_done = 1'b1;
        end
        S_BR: begin
          ALUSrcA    = 1'b1;
          ALUCtr     = ALU_SUB;
          PCWrCond   = 1'b1;
          PCSrc      = 2'b01;
          instr_done = 1'b1;
        end
        S_JMP: begin
          PCWr       = 1'b1;
          PCSrc      = 2'b10;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] OpCode = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       mem_ready = 1'b0;
  logic       Zero = 1'b0;
  logic       MemRd, MemWr, IorD, IRWr, PCWr, PCWrCond, RegDst, RegWr, Mem2Reg;
  logic       ALUSrcA, ExtOp, instr_done, illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUCtr;

  multi_cycle_ctrl dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct),
    .mem_ready(mem_ready), .Zero(Zero),
    .MemRd(MemRd), .MemWr(MemWr), .IorD(IorD), .IRWr(IRWr), .PCWr(PCWr),
    .PCWrCond(PCWrCond), .RegDst(RegDst), .RegWr(RegWr), .Mem2Reg(Mem2Reg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .PCSrc(PCSrc),
    .ALUCtr(ALUCtr), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {MemRd,MemWr,IorD,IRWr,PCWr,PCWrCond,RegDst,RegWr,Mem2Reg,ALUSrcA,
  //  ALUSrcB[1:0],ExtOp,PCSrc[1:0],ALUCtr[3:0],instr_done,illegal}
  logic [20:0] got, exp_vec;
  logic        exp_valid = 1'b0;
  string       tag = "idle";
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc_no = 0;

  assign got = {MemRd, MemWr, IorD, IRWr, PCWr, PCWrCond, RegDst, RegWr, Mem2Reg,
                ALUSrcA, ALUSrcB, ExtOp, PCSrc, ALUCtr, instr_done, illegal};

  always @(negedge clk) begin
    if (exp_valid) begin
      n_tests++;
      if (got !== exp_vec) begin
        n_fail++;
        $display("FAIL %s cycle=%0d outputs got=%b want=%b", tag, cyc_no, got, exp_vec);
      end
    end
  end

  function automatic logic [20:0] v(
    input logic memrd, memwr, iord, irwr, pcwr, pcwrcond, regdst, regwr, mem2reg, srca,
    input logic [1:0] srcb, input logic extop, input logic [1:0] pcsrc,
    input logic [3:0] ctr, input logic done, input logic ill);
    return {memrd, memwr, iord, irwr, pcwr, pcwrcond, regdst, regwr, mem2reg, srca,
            srcb, extop, pcsrc, ctr, done, ill};
  endfunction

  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND_ = 4'b0000,
                         OR_ = 4'b0001, SLT = 4'b0111;

  // One clock of stimulus with the model's expectation for that clock.
  task automatic cyc(input logic r, input logic mr, input logic [20:0] e);
    rst = r;
    mem_ready = mr;
    exp_vec = e;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  // Instruction-level model: expands one instruction into its expected
  // per-cycle control word from the opcode/funct and the wait counts the
  // bench chooses, and returns how many cycles it occupied.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, output int len);
    logic [3:0] ctr;
    logic       ok;
    len = 0;
    tag = name;
    OpCode = op;
    Funct = fn;
    for (int i = 0; i < fw; i++) begin
      cyc(0, 0, v(1,0,0,0,0,0,0,0,0,0,2'b01,0,2'b00,ADD,0,0)); len++;
    end
    cyc(0, 1, v(1,0,0,1,1,0,0,0,0,0,2'b01,0,2'b00,ADD,0,0)); len++;
    case (op)
      6'b000000: begin
        ok = 1'b1;
        case (fn)
          6'b100000: ctr = ADD;
          6'b100010: ctr = SUB;
          6'b100100: ctr = AND_;
          6'b100101: ctr = OR_;
          6'b101010: ctr = SLT;
          default: begin ctr = ADD; ok = 1'b0; end
        endcase
        cyc(0, 1, v(0,0,0,0,0,0,0,0,0,0,2'b11,1,2'b00,ADD,0,0)); len++;
        cyc(0, 1, v(0,0,0,0,0,0,0,0,0,1,2'b00,0,2'b00,ctr,0,!ok)); len++;
        if (ok) begin
          cyc(0, 1, v(0,0,0,0,0,0,1,1,0,0,2'b00,0,2'b00,4'b0000,1,0)); len++;
        end
      end
      6'b100011, 6'b101011: begin
        cyc(0, 1, v(0,0,0,0,0,0,0,0,0,0,2'b11,1,2'b00,ADD,0,0)); len++;
        cyc(0, 0, v(0,0,0,0,0,0,0,0,0,1,2'b10,1,2'b00,ADD,0,0)); len++;
        if (op == 6'b100011) begin
          for (int i = 0; i < mw; i++) begin
            cyc(0, 0, v(1,0,1,0,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0)); len++;
          end
          cyc(0, 1, v(1,0,1,0,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0)); len++;
          cyc(0, 1, v(0,0,0,0,0,0,0,1,1,0,2'b00,0,2'b00,4'b0000,1,0)); len++;
        end else begin
          for (int i = 0; i < mw; i++) begin
            cyc(0, 0, v(0,1,1,0,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0)); len++;
          end
          cyc(0, 1, v(0,1,1,0,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,1,0)); len++;
        end
      end
      6'b001000, 6'b001101: begin
        cyc(0, 1, v(0,0,0,0,0,0,0,0,0,0,2'b11,1,2'b00,ADD,0,0)); len++;
        if (op == 6'b001101)
          cyc(0, 0, v(0,0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,OR_,0,0));
        else
          cyc(0, 0, v(0,0,0,0,0,0,0,0,0,1,2'b10,1,2'b00,ADD,0,0));
        len++;
        cyc(0, 1, v(0,0,0,0,0,0,0,1,0,0,2'b00,0,2'b00,4'b0000,1,0)); len++;
      end
      6'b000100: begin
        cyc(0, 1, v(0,0,0,0,0,0,0,0,0,0,2'b11,1,2'b00,ADD,0,0)); len++;
        cyc(0, 0, v(0,0,0,0,0,1,0,0,0,1,2'b00,0,2'b01,SUB,1,0)); len++;
      end
      6'b000010: begin
        cyc(0, 0, v(0,0,0,0,0,0,0,0,0,0,2'b11,1,2'b00,ADD,0,0)); len++;
        cyc(0, 1, v(0,0,0,0,1,0,0,0,0,0,2'b00,0,2'b10,4'b0000,1,0)); len++;
      end
      default: begin
        cyc(0, 1, v(0,0,0,0,0,0,0,0,0,0,2'b11,1,2'b00,ADD,0,1)); len++;
      end
    endcase
  endtask

  // Pins the model's cycle count against a hand-computed latency.
  task automatic chk_len(input string name, input int got_len, input int want);
    n_tests++;
    if (got_len != want) begin
      n_fail++;
      $display("FAIL %s latency got=%0d want=%0d", name, got_len, want);
    end
  endtask

  task automatic instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input int fw, input int mw, input int want);
    int len;
    run_instr(name, op, fn, fw, mw, len);
    chk_len(name, len, want);
  endtask

  initial begin
    #1;
    tag = "reset";
    for (int i = 0; i < 3; i++) cyc(1, 1, 21'd0);

    instr("add",        6'b000000, 6'b100000, 0, 0, 4);
    instr("slt",        6'b000000, 6'b101010, 0, 0, 4);
    instr("lw_2wait",   6'b100011, 6'b000000, 0, 2, 7);
    instr("sw",         6'b101011, 6'b000000, 0, 0, 4);
    Zero = 1'b1;
    instr("beq_z1",     6'b000100, 6'b000000, 0, 0, 3);
    Zero = 1'b0;
    instr("beq_z0",     6'b000100, 6'b000000, 0, 0, 3);
    instr("j",          6'b000010, 6'b000000, 0, 0, 3);
    instr("ori",        6'b001101, 6'b000000, 0, 0, 4);
    instr("addi",       6'b001000, 6'b000000, 0, 0, 4);
    instr("sub",        6'b000000, 6'b100010, 0, 0, 4);
    instr("and",        6'b000000, 6'b100100, 0, 0, 4);
    instr("or",         6'b000000, 6'b100101, 0, 0, 4);
    instr("lw_fwait",   6'b100011, 6'b000000, 1, 0, 6);
    instr("sw_1wait",   6'b101011, 6'b000000, 2, 1, 7);
    instr("ill_op",     6'b111111, 6'b000000, 0, 0, 2);
    instr("ill_funct",  6'b000000, 6'b000111, 0, 0, 3);

    // lw abandoned by reset while waiting in MR
    tag = "lw_abort";
    OpCode = 6'b100011;
    cyc(0, 1, v(1,0,0,1,1,0,0,0,0,0,2'b01,0,2'b00,ADD,0,0));
    cyc(0, 1, v(0,0,0,0,0,0,0,0,0,0,2'b11,1,2'b00,ADD,0,0));
    cyc(0, 1, v(0,0,0,0,0,0,0,0,0,1,2'b10,1,2'b00,ADD,0,0));
    cyc(0, 0, v(1,0,1,0,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0));
    tag = "lw_abort_rst";
    cyc(1, 1, 21'd0);
    instr("add_after",  6'b000000, 6'b100000, 0, 0, 4);

    // sw abandoned by reset while waiting in MW
    tag = "sw_abort";
    OpCode = 6'b101011;
    cyc(0, 1, v(1,0,0,1,1,0,0,0,0,0,2'b01,0,2'b00,ADD,0,0));
    cyc(0, 1, v(0,0,0,0,0,0,0,0,0,0,2'b11,1,2'b00,ADD,0,0));
    cyc(0, 1, v(0,0,0,0,0,0,0,0,0,1,2'b10,1,2'b00,ADD,0,0));
    cyc(0, 0, v(0,1,1,0,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0));
    tag = "sw_abort_rst";
    cyc(1, 0, 21'd0);
    instr("ori_after",  6'b001101, 6'b000000, 0, 0, 4);

    exp_valid = 1'b0;
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
